// File: rtl/second_max_pkg.sv
// second_max_pkg: shared widths, event record and drop-counter limit for the event logger
package second_max_pkg;
  localparam int DATA_W = 8;
  localparam int TS_W = 16;
  localparam logic [7:0] DROP_MAX = 8'hFF;
  typedef struct packed {
    logic [TS_W-1:0] ts;
    logic [DATA_W-1:0] data;
  } evt_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with pop-then-push when full and valid/ready read side
module sync_fifo #(
  parameter int W = 24,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  output logic          rvalid,
  input  logic          rready,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic pop, wr;
  assign full = count_q == CW'(DEPTH);
  assign rvalid = count_q != '0;
  assign pop = rvalid && rready;
  assign wr = push && (!full || pop);
  assign rdata = rvalid ? mem_q[rd_q] : '0;
  assign count = count_q;
  always_comb begin
    wr_d = wr ? wr_q + 1'b1 : wr_q;
    rd_d = pop ? rd_q + 1'b1 : rd_q;
    count_d = count_q + CW'(wr) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_q] <= wdata;
  end
endmodule

// File: rtl/second_max_event_logger.sv
// second_max_event_logger: timestamps changes of the tracked second-highest value into a drainable FIFO
module second_max_event_logger #(
  parameter int DATA_W = second_max_pkg::DATA_W,
  parameter int TS_W = second_max_pkg::TS_W,
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              clr_ovf,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [DATA_W-1:0] evt_data,
  output logic [TS_W-1:0]   evt_time,
  output logic [CW-1:0]     fifo_count,
  output logic              overflow,
  output logic [7:0]        drop_count
);
  import second_max_pkg::*;
  logic [TS_W-1:0] ts_q, ts_d;
  logic [DATA_W-1:0] last_q, last_d;
  logic have_q, have_d, ovf_q, ovf_d, evt, full, drop;
  logic [7:0] drop_q, drop_d;
  logic [TS_W+DATA_W-1:0] rdata;
  assign evt = in_valid && (!have_q || in_data != last_q);
  assign drop = evt && full && !(evt_valid && evt_ready);
  assign {evt_time, evt_data} = rdata;
  assign overflow = ovf_q;
  assign drop_count = drop_q;
  always_comb begin
    ts_d = ts_q + 1'b1;
    last_d = evt ? in_data : last_q;
    have_d = have_q | evt;
    ovf_d = drop | (ovf_q & ~clr_ovf);
    drop_d = drop ? (clr_ovf ? 8'd1 : drop_q == DROP_MAX ? drop_q : drop_q + 8'd1)
                  : clr_ovf ? 8'd0 : drop_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ts_q <= '0;
      last_q <= '0;
      have_q <= 1'b0;
      ovf_q <= 1'b0;
      drop_q <= '0;
    end else begin
      ts_q <= ts_d;
      last_q <= last_d;
      have_q <= have_d;
      ovf_q <= ovf_d;
      drop_q <= drop_d;
    end
  end
  sync_fifo #(.W(TS_W + DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(evt),
    .wdata({ts_q, in_data}),
    .rvalid(evt_valid),
    .rready(evt_ready),
    .rdata(rdata),
    .full(full),
    .count(fifo_count)
  );
endmodule
